// File: rtl/sys_bus_arbiter_if.sv
// Bus bundle between hosts/devices and the sys_bus_arbiter interconnect.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (bus hosts plus memory-mapped devices).
interface sys_bus_arbiter_if #(
  parameter int NrHosts   = 2,
  parameter int NrDevices = 5,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  // Host side
  logic [NrHosts-1:0]                   host_req_i;
  logic [NrHosts-1:0]                   host_gnt_o;
  logic [NrHosts*AddrWidth-1:0]         host_addr_i;
  logic [NrHosts-1:0]                   host_we_i;
  logic [NrHosts*(DataWidth/8)-1:0]     host_be_i;
  logic [NrHosts*DataWidth-1:0]         host_wdata_i;
  logic [NrHosts-1:0]                   host_rvalid_o;
  logic [DataWidth-1:0]                 host_rdata_o;
  logic [NrHosts-1:0]                   host_err_o;
  // Device side
  logic [NrDevices-1:0]                 device_req_o;
  logic [AddrWidth-1:0]                 device_addr_o;
  logic                                 device_we_o;
  logic [DataWidth/8-1:0]               device_be_o;
  logic [DataWidth-1:0]                 device_wdata_o;
  logic [NrDevices-1:0]                 device_rvalid_i;
  logic [NrDevices*DataWidth-1:0]       device_rdata_i;
  logic [NrDevices-1:0]                 device_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  device_rvalid_i, device_rdata_i, device_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output device_rvalid_i, device_rdata_i, device_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// N-host / M-device single-outstanding bus interconnect: round-robin grant,
// address decode with decode-error responses, variable device latency and a
// per-transaction response timeout.
module sys_bus_arbiter #(
  parameter int NrHosts   = 2,
  parameter int NrDevices = 5,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  // Default map assumes 5 devices of 32-bit address; device d at [d*AddrWidth +: AddrWidth].
  parameter logic [NrDevices*AddrWidth-1:0] DevBase = {
    32'h0020_0000, 32'h0020_0000, 32'h0012_0000, 32'h0011_0000, 32'h0010_0000},
  parameter logic [NrDevices*AddrWidth-1:0] DevMask = {
    32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sys_bus_arbiter_if.slave bus,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int CntW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int BeW      = DataWidth / 8;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StDecErr} state_e;

  state_e                state_q, state_d;
  logic [HostIdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HostIdxW-1:0]   cur_host_q, cur_host_d;
  logic [DevIdxW-1:0]    cur_dev_q, cur_dev_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  arb_valid;
  logic [HostIdxW-1:0]   arb_host;
  logic [HostIdxW-1:0]   arb_cand;
  logic [AddrWidth-1:0]  sel_addr;
  logic                  dec_hit;
  logic [DevIdxW-1:0]    dec_dev;

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin
    arb_valid = 1'b0;
    arb_host  = '0;
    arb_cand  = '0;
    for (int i = 1; i <= NrHosts; i++) begin
      arb_cand = HostIdxW'((int'(rr_ptr_q) + i) % NrHosts);
      if (!arb_valid && bus.host_req_i[arb_cand]) begin
        arb_valid = 1'b1;
        arb_host  = arb_cand;
      end
    end
  end

  assign sel_addr = bus.host_addr_i[int'(arb_host)*AddrWidth +: AddrWidth];

  // Address decode; scanned high-to-low so the lowest matching device wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & DevMask[d*AddrWidth +: AddrWidth]) == DevBase[d*AddrWidth +: AddrWidth]) begin
        dec_hit = 1'b1;
        dec_dev = DevIdxW'(d);
      end
    end
  end

  // Next-state and bus outputs; everything is quiet while reset is asserted.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latch).
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    cur_host_d          = cur_host_q;
    cur_dev_d           = cur_dev_q;
    cnt_d               = cnt_q;
    bus.host_gnt_o      = '0;
    bus.host_rvalid_o   = '0;
    bus.host_rdata_o    = '0;
    bus.host_err_o      = '0;
    bus.device_req_o    = '0;
    bus.device_addr_o   = '0;
    bus.device_we_o     = 1'b0;
    bus.device_be_o     = '0;
    bus.device_wdata_o  = '0;
    timeout_o           = 1'b0;

    if (!rst_i) begin
      case (state_q)
        StIdle: begin
          if (arb_valid) begin
            bus.host_gnt_o[arb_host] = 1'b1;
            bus.device_addr_o        = sel_addr;
            bus.device_we_o          = bus.host_we_i[arb_host];
            bus.device_be_o          = bus.host_be_i[int'(arb_host)*BeW +: BeW];
            bus.device_wdata_o       = bus.host_wdata_i[int'(arb_host)*DataWidth +: DataWidth];
            rr_ptr_d                 = arb_host;
            cur_host_d               = arb_host;
            if (dec_hit) begin
              bus.device_req_o[dec_dev] = 1'b1;
              cur_dev_d                 = dec_dev;
              cnt_d                     = '0;
              state_d                   = StWait;
            end else begin
              state_d = StDecErr;
            end
          end
        end
        StWait: begin
          if (bus.device_rvalid_i[cur_dev_q]) begin
            bus.host_rvalid_o[cur_host_q] = 1'b1;
            bus.host_rdata_o              = bus.device_rdata_i[int'(cur_dev_q)*DataWidth +: DataWidth];
            bus.host_err_o[cur_host_q]    = bus.device_err_i[cur_dev_q];
            state_d                       = StIdle;
          end else if (TimeoutCycles != 0 && cnt_q == CntLast) begin
            bus.host_rvalid_o[cur_host_q] = 1'b1;
            bus.host_err_o[cur_host_q]    = 1'b1;
            timeout_o                     = 1'b1;
            state_d                       = StIdle;
          end else if (TimeoutCycles != 0) begin
            // Counter stops at CntLast (response issued), so it can never wrap.
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDecErr: begin
          bus.host_rvalid_o[cur_host_q] = 1'b1;
          bus.host_err_o[cur_host_q]    = 1'b1;
          state_d                       = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

  // State registers with synchronous reset; rr_ptr resets so host 0 wins first.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= HostIdxW'(NrHosts - 1);
      cur_host_q <= '0;
      cur_dev_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_host_q <= cur_host_d;
      cur_dev_q  <= cur_dev_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: directed corner sequences, a
// vector table of single transactions, then random traffic against a
// transaction-level reference model.
module tb_sys_bus_arbiter;
  localparam int NH = 2;
  localparam int ND = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam logic [31:0] BASE [ND] = '{32'h0010_0000, 32'h0011_0000, 32'h0012_0000,
                                        32'h0020_0000, 32'h0020_0000};
  localparam logic [31:0] MASK [ND] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                        32'hFFFF_0000, 32'hFFF0_0000};
  localparam logic [ND*AW-1:0] DEV_BASE = {32'h0020_0000, 32'h0020_0000, 32'h0012_0000,
                                           32'h0011_0000, 32'h0010_0000};
  localparam logic [ND*AW-1:0] DEV_MASK = {32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                           32'hFFFF_0000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic rst;
  logic busy, tout;

  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.NrHosts(NH), .NrDevices(ND), .AddrWidth(AW), .DataWidth(DW)) bus ();

  sys_bus_arbiter #(
    .NrHosts(NH), .NrDevices(ND), .AddrWidth(AW), .DataWidth(DW),
    .DevBase(DEV_BASE), .DevMask(DEV_MASK), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy), .timeout_o(tout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus state
  logic [NH-1:0] h_req, h_we;
  logic [31:0]   h_addr [NH];
  logic [3:0]    h_be [NH];
  logic [31:0]   h_wdata [NH];
  logic [ND-1:0] d_rvalid, d_err;
  logic [31:0]   d_rdata [ND];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    int          lat;
    logic        derr;
    logic [1:0]  gnt;
    logic [4:0]  dreq;
    logic        err;
  } vec_t;
  vec_t vecs [10];

  // Reference model state
  int   m_last, m_host, m_dev, m_gcyc, w, dd, j;
  bit   m_busy, resp;
  int   resp_at [ND];
  bit   granted [NH];
  logic [1:0]  e_gnt, e_rv, e_err;
  logic [4:0]  e_dreq;
  logic [31:0] e_rdata, ex_rdata;
  logic        e_to;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.host_req_i = h_req;
    bus.host_we_i  = h_we;
    for (int h = 0; h < NH; h++) begin
      bus.host_addr_i[h*AW +: AW]  = h_addr[h];
      bus.host_be_i[h*4 +: 4]      = h_be[h];
      bus.host_wdata_i[h*DW +: DW] = h_wdata[h];
    end
    bus.device_rvalid_i = d_rvalid;
    bus.device_err_i    = d_err;
    for (int d = 0; d < ND; d++) bus.device_rdata_i[d*DW +: DW] = d_rdata[d];
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    h_req = '0; h_we = '0; d_rvalid = '0; d_err = '0;
    for (int h = 0; h < NH; h++) begin
      h_addr[h] = '0; h_be[h] = '0; h_wdata[h] = '0;
    end
    for (int d = 0; d < ND; d++) d_rdata[d] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    apply();
    step();
    step();
    rst = 1'b0;
    apply();
  endtask

  function automatic int rr_winner(input logic [NH-1:0] req, input int last);
    for (int k = 1; k <= NH; k++) if (req[(last + k) % NH]) return (last + k) % NH;
    return -1;
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int d = 0; d < ND; d++) if ((a & MASK[d]) == BASE[d]) return d;
    return -1;
  endfunction

  initial begin
    vecs[0] = '{2'b01, 32'h0010_0000, 32'h0000_0000, 1,  1'b0, 2'b01, 5'b00001, 1'b0};
    vecs[1] = '{2'b11, 32'h0011_FFFC, 32'h0012_0000, 2,  1'b0, 2'b10, 5'b00100, 1'b0};
    vecs[2] = '{2'b11, 32'h0020_1234, 32'h0011_0000, 3,  1'b1, 2'b01, 5'b01000, 1'b1};
    vecs[3] = '{2'b11, 32'h0010_0000, 32'h0021_0000, 1,  1'b0, 2'b10, 5'b10000, 1'b0};
    vecs[4] = '{2'b10, 32'h0000_0000, 32'h0010_FFFF, 1,  1'b1, 2'b10, 5'b00001, 1'b1};
    vecs[5] = '{2'b10, 32'h0000_0000, 32'h000F_FFFC, 1,  1'b0, 2'b10, 5'b00000, 1'b1};
    vecs[6] = '{2'b11, 32'h0013_0000, 32'h0010_0000, 1,  1'b0, 2'b01, 5'b00000, 1'b1};
    vecs[7] = '{2'b01, 32'h0030_0000, 32'h0000_0000, 1,  1'b0, 2'b01, 5'b00000, 1'b1};
    vecs[8] = '{2'b11, 32'h0011_0008, 32'h002F_FFFC, 4,  1'b0, 2'b10, 5'b10000, 1'b0};
    vecs[9] = '{2'b01, 32'h0011_0008, 32'h0000_0000, 15, 1'b1, 2'b01, 5'b00010, 1'b1};

    // Reset state: requests present while reset is held must not be granted
    rst = 1'b1;
    clear_inputs();
    h_req = 2'b11;
    h_addr[0] = 32'h0010_0000;
    apply();
    @(negedge clk);
    step();
    apply();
    check("rst_gnt",    64'(bus.host_gnt_o),    64'(0));
    check("rst_dreq",   64'(bus.device_req_o),  64'(0));
    check("rst_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    check("rst_rdata",  64'(bus.host_rdata_o),  64'(0));
    check("rst_busy",   64'(busy),              64'(0));
    check("rst_tout",   64'(tout),              64'(0));
    rst = 1'b0;
    h_req = '0;
    apply();

    // 1: basic read to dev0 with one-cycle device latency
    h_req = 2'b01; h_addr[0] = 32'h0010_0010;
    apply();
    check("t1_gnt",   64'(bus.host_gnt_o),    64'(2'b01));
    check("t1_dreq",  64'(bus.device_req_o),  64'(5'b00001));
    check("t1_daddr", 64'(bus.device_addr_o), 64'(32'h0010_0010));
    check("t1_busy0", 64'(busy),              64'(0));
    step();
    h_req = '0; d_rvalid = 5'b00001; d_rdata[0] = 32'h1234_5678;
    apply();
    check("t1_rvalid", 64'(bus.host_rvalid_o), 64'(2'b01));
    check("t1_rdata",  64'(bus.host_rdata_o),  64'(32'h1234_5678));
    check("t1_err",    64'(bus.host_err_o),    64'(0));
    check("t1_busy1",  64'(busy),              64'(1));
    step();
    d_rvalid = '0;
    apply();
    check("t1_done_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    check("t1_done_busy",   64'(busy),              64'(0));

    // 2: two hosts requesting continuously alternate every other cycle
    do_reset();
    h_req = 2'b11; h_addr[0] = 32'h0010_0000; h_addr[1] = 32'h0011_0000;
    for (int t = 0; t < 8; t++) begin
      d_rvalid = (t % 2 == 1) ? 5'b00011 : 5'b00000;
      apply();
      check("t2_gnt", 64'(bus.host_gnt_o),
            64'((t % 2 == 1) ? 2'b00 : ((t % 4 == 0) ? 2'b01 : 2'b10)));
      if (t % 2 == 1)
        check("t2_rvalid", 64'(bus.host_rvalid_o), 64'((t % 4 == 1) ? 2'b01 : 2'b10));
      step();
    end
    h_req = '0; d_rvalid = '0;
    apply();

    // 3: write to an unmapped address gets a decode error
    h_req = 2'b10; h_we = 2'b10; h_addr[1] = 32'h4000_0000;
    apply();
    check("t3_gnt",  64'(bus.host_gnt_o),   64'(2'b10));
    check("t3_dreq", 64'(bus.device_req_o), 64'(0));
    step();
    h_req = '0; h_we = '0; d_rvalid = '1;
    for (int d = 0; d < ND; d++) d_rdata[d] = 32'hDEAD_BEEF;
    apply();
    check("t3_rvalid", 64'(bus.host_rvalid_o), 64'(2'b10));
    check("t3_err",    64'(bus.host_err_o),    64'(2'b10));
    check("t3_rdata",  64'(bus.host_rdata_o),  64'(0));
    step();
    d_rvalid = '0;
    apply();

    // 4: silent device times out at T16; late response at T20 is ignored
    h_req = 2'b01; h_addr[0] = 32'h0011_0004;
    apply();
    check("t4_gnt",  64'(bus.host_gnt_o),   64'(2'b01));
    check("t4_dreq", 64'(bus.device_req_o), 64'(5'b00010));
    step();
    h_req = '0;
    for (int t = 1; t < TO; t++) begin
      apply();
      check("t4_wait_rvalid", 64'(bus.host_rvalid_o), 64'(0));
      check("t4_wait_tout",   64'(tout),              64'(0));
      step();
    end
    h_req = 2'b10; h_addr[1] = 32'h0012_0000;
    apply();
    check("t4_to_rvalid", 64'(bus.host_rvalid_o), 64'(2'b01));
    check("t4_to_err",    64'(bus.host_err_o),    64'(2'b01));
    check("t4_to_rdata",  64'(bus.host_rdata_o),  64'(0));
    check("t4_to_pulse",  64'(tout),              64'(1));
    check("t4_to_nognt",  64'(bus.host_gnt_o),    64'(0));
    step();
    apply();
    check("t4_next_gnt",  64'(bus.host_gnt_o),   64'(2'b10));
    check("t4_next_dreq", 64'(bus.device_req_o), 64'(5'b00100));
    check("t4_tout_low",  64'(tout),             64'(0));
    step();
    h_req = '0;
    apply(); step();
    apply(); step();
    d_rvalid = 5'b00010;
    apply();
    check("t4_late_ignored", 64'(bus.host_rvalid_o), 64'(0));
    step();
    d_rvalid = 5'b00100; d_rdata[2] = 32'h0BAD_F00D; d_err = '0;
    apply();
    check("t4_dev2_rvalid", 64'(bus.host_rvalid_o), 64'(2'b10));
    check("t4_dev2_rdata",  64'(bus.host_rdata_o),  64'(32'h0BAD_F00D));
    step();
    d_rvalid = '0;
    apply();

    // 5: reset during WAIT abandons the transaction; host 0 wins afterwards
    h_req = 2'b01; h_addr[0] = 32'h0010_0000;
    apply();
    check("t5_gnt", 64'(bus.host_gnt_o), 64'(2'b01));
    step();
    h_req = '0;
    for (int t = 1; t < 3; t++) begin
      apply();
      check("t5_wait_rvalid", 64'(bus.host_rvalid_o), 64'(0));
      step();
    end
    rst = 1'b1; d_rvalid = 5'b00001;
    apply();
    check("t5_rst_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    step();
    rst = 1'b0; h_req = 2'b11; h_addr[1] = 32'h0011_0000;
    apply();
    check("t5_busy",   64'(busy),              64'(0));
    check("t5_rvalid", 64'(bus.host_rvalid_o), 64'(0));
    check("t5_gnt0",   64'(bus.host_gnt_o),    64'(2'b01));
    step();
    h_req = 2'b10;
    apply();
    check("t5_resp0", 64'(bus.host_rvalid_o), 64'(2'b01));
    step();
    d_rvalid = '0;
    apply();
    check("t5_gnt1", 64'(bus.host_gnt_o), 64'(2'b10));
    step();
    h_req = '0; d_rvalid = 5'b00010;
    apply();
    check("t5_resp1", 64'(bus.host_rvalid_o), 64'(2'b10));
    step();
    d_rvalid = '0;
    apply();

    // 6: write with partial byte enables; device answers after 3 cycles with error
    h_req = 2'b01; h_we = 2'b01; h_be[0] = 4'b0011; h_wdata[0] = 32'hA5A5_A5A5;
    h_addr[0] = 32'h0012_0004;
    apply();
    check("t6_gnt",   64'(bus.host_gnt_o),     64'(2'b01));
    check("t6_dreq",  64'(bus.device_req_o),   64'(5'b00100));
    check("t6_be",    64'(bus.device_be_o),    64'(4'b0011));
    check("t6_wdata", 64'(bus.device_wdata_o), 64'(32'hA5A5_A5A5));
    check("t6_we",    64'(bus.device_we_o),    64'(1));
    step();
    h_req = '0; h_we = '0;
    for (int t = 1; t < 3; t++) begin
      apply();
      check("t6_wait_rvalid", 64'(bus.host_rvalid_o), 64'(0));
      step();
    end
    d_rvalid = 5'b00100; d_err = 5'b00100;
    apply();
    check("t6_rvalid", 64'(bus.host_rvalid_o), 64'(2'b01));
    check("t6_err",    64'(bus.host_err_o),    64'(2'b01));
    step();
    clear_inputs();
    apply();

    // Vector table: one transaction per record, from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      h_req = vecs[i].req; h_addr[0] = vecs[i].a0; h_addr[1] = vecs[i].a1; d_rvalid = '0;
      apply();
      check($sformatf("v%0d_gnt", i),  64'(bus.host_gnt_o),   64'(vecs[i].gnt));
      check($sformatf("v%0d_dreq", i), 64'(bus.device_req_o), 64'(vecs[i].dreq));
      step();
      h_req = '0;
      for (int d = 0; d < ND; d++) d_rdata[d] = 32'hD000_0000 + 32'(d * 256 + i);
      d_err = vecs[i].derr ? vecs[i].dreq : ~vecs[i].dreq;
      ex_rdata = '0;
      for (int d = 0; d < ND; d++) if (vecs[i].dreq[d]) ex_rdata = d_rdata[d];
      if (vecs[i].dreq != '0) begin
        for (int k = 1; k < vecs[i].lat; k++) begin
          d_rvalid = ~vecs[i].dreq;
          apply();
          check($sformatf("v%0d_wait", i), 64'(bus.host_rvalid_o), 64'(0));
          step();
        end
        d_rvalid = vecs[i].dreq;
      end
      apply();
      check($sformatf("v%0d_rvalid", i), 64'(bus.host_rvalid_o), 64'(vecs[i].gnt));
      check($sformatf("v%0d_err", i),    64'(bus.host_err_o),    64'(vecs[i].err ? vecs[i].gnt : 2'b00));
      check($sformatf("v%0d_rdata", i),  64'(bus.host_rdata_o),  64'(ex_rdata));
      step();
      d_rvalid = '0;
      apply();
    end

    // Random traffic against the transaction-level model
    do_reset();
    m_last = NH - 1; m_busy = 0; m_host = 0; m_dev = -1; m_gcyc = 0;
    for (int d = 0; d < ND; d++) resp_at[d] = -1;
    for (int h = 0; h < NH; h++) granted[h] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int h = 0; h < NH; h++) begin
        if (granted[h]) begin
          h_req[h] = 1'b0;
          granted[h] = 0;
        end
        if (!h_req[h] && $urandom_range(0, 2) == 0) begin
          h_req[h] = 1'b1;
          case ($urandom_range(0, 6))
            0: h_addr[h] = 32'h0010_0000 | 32'($urandom_range(0, 16'hFFFF));
            1: h_addr[h] = 32'h0011_0000 | 32'($urandom_range(0, 16'hFFFF));
            2: h_addr[h] = 32'h0012_0000 | 32'($urandom_range(0, 16'hFFFF));
            3: h_addr[h] = 32'h0020_0000 | 32'($urandom_range(0, 16'hFFFF));
            4: h_addr[h] = 32'h0021_0000 | 32'($urandom_range(0, 16'hFFFF));
            5: h_addr[h] = 32'h4000_0000 | 32'($urandom_range(0, 16'hFFFF));
            default: h_addr[h] = $urandom;
          endcase
          h_we[h] = 1'($urandom); h_be[h] = 4'($urandom); h_wdata[h] = $urandom;
        end
      end
      for (int d = 0; d < ND; d++) begin
        d_rvalid[d] = (resp_at[d] == c);
        if (resp_at[d] == c) resp_at[d] = -1;
        d_rdata[d] = $urandom;
        d_err[d]   = 1'($urandom);
      end
      if ($urandom_range(0, 5) == 0) d_rvalid[$urandom_range(0, ND - 1)] = 1'b1;
      apply();

      e_gnt = '0; e_dreq = '0; e_rv = '0; e_err = '0; e_rdata = '0; e_to = 1'b0;
      w = -1; dd = -1; resp = 0;
      if (!m_busy) begin
        w = rr_winner(h_req, m_last);
        if (w >= 0) begin
          e_gnt[w] = 1'b1;
          dd = decode(h_addr[w]);
          if (dd >= 0) e_dreq[dd] = 1'b1;
          check("rnd_daddr",  64'(bus.device_addr_o),  64'(h_addr[w]));
          check("rnd_dwe",    64'(bus.device_we_o),    64'(h_we[w]));
          check("rnd_dbe",    64'(bus.device_be_o),    64'(h_be[w]));
          check("rnd_dwdata", 64'(bus.device_wdata_o), 64'(h_wdata[w]));
        end
      end else if (m_dev < 0) begin
        resp = 1; e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1;
      end else if (d_rvalid[m_dev]) begin
        resp = 1; e_rv[m_host] = 1'b1; e_err[m_host] = d_err[m_dev]; e_rdata = d_rdata[m_dev];
      end else if (c - m_gcyc == TO) begin
        resp = 1; e_rv[m_host] = 1'b1; e_err[m_host] = 1'b1; e_to = 1'b1;
      end
      check("rnd_gnt",    64'(bus.host_gnt_o),    64'(e_gnt));
      check("rnd_dreq",   64'(bus.device_req_o),  64'(e_dreq));
      check("rnd_rvalid", 64'(bus.host_rvalid_o), 64'(e_rv));
      check("rnd_err",    64'(bus.host_err_o),    64'(e_err));
      check("rnd_rdata",  64'(bus.host_rdata_o),  64'(e_rdata));
      check("rnd_tout",   64'(tout),              64'(e_to));
      check("rnd_busy",   64'(busy),              64'(m_busy));

      if (!m_busy && w >= 0) begin
        m_busy = 1; m_host = w; m_dev = dd; m_gcyc = c; m_last = w; granted[w] = 1;
        if (dd >= 0) resp_at[dd] = c + $urandom_range(1, 20);
      end else if (m_busy && resp) begin
        m_busy = 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
